// File: rtl/divisor_seq_pkg.sv
// Shared widths, iteration count and state encoding for the sequential divider.
package divisor_seq_pkg;

  localparam int unsigned DVD_W  = 32;
  localparam int unsigned DVS_W  = 16;
  localparam int unsigned REM_W  = DVS_W + 1;
  localparam int unsigned ITER_N = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/divisor_seq_passo.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module divisor_passo
  import divisor_seq_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] dvs,
  output logic [REM_W-1:0] rem_nxt_c,
  output logic             qbit_c
);

  logic [REM_W-1:0] partial;
  logic [REM_W-1:0] dvs_ext;

  // Remainder entering a step is always below the divisor, so the shifted value fits in 17 bits.
  always_comb begin
    dvs_ext   = REM_W'(dvs);
    partial   = (rem << 1) | REM_W'(bit_in);
    qbit_c    = 1'b0;
    rem_nxt_c = partial;
    if (partial >= dvs_ext) begin
      qbit_c    = 1'b1;
      rem_nxt_c = partial - dvs_ext;
    end
  end

endmodule

// File: rtl/divisor_seq.sv
// Sequential 32/16 unsigned restoring divider: one quotient bit per clock, with overflow pre-check.
module divisor_seq
  import divisor_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             st,
  input  logic [DVD_W-1:0] dividendo,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] quociente,
  output logic [DVS_W-1:0] resto,
  output logic             idle,
  output logic             done,
  output logic             ovf
);

  state_t           state_q, state_nxt;
  logic [REM_W-1:0] rem_q, rem_nxt;
  logic [DVS_W-1:0] work_q, work_nxt;
  logic [DVS_W-1:0] dvs_q, dvs_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [DVS_W-1:0] quo_nxt, resto_nxt;
  logic             ovf_nxt, idle_nxt, done_nxt;

  logic [REM_W-1:0] step_rem_c;
  logic             step_q_c;

  // Single shared step datapath; work_q supplies dividend bits MSB first and collects quotient bits.
  divisor_passo u_passo (
    .rem       (rem_q),
    .bit_in    (work_q[DVS_W-1]),
    .dvs       (dvs_q),
    .rem_nxt_c (step_rem_c),
    .qbit_c    (step_q_c)
  );

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      work_q    <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quociente <= '0;
      resto     <= '0;
      ovf       <= 1'b0;
      idle      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rem_q     <= rem_nxt;
      work_q    <= work_nxt;
      dvs_q     <= dvs_nxt;
      cnt_q     <= cnt_nxt;
      quociente <= quo_nxt;
      resto     <= resto_nxt;
      ovf       <= ovf_nxt;
      idle      <= idle_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state_q;
    rem_nxt   = rem_q;
    work_nxt  = work_q;
    dvs_nxt   = dvs_q;
    cnt_nxt   = cnt_q;
    quo_nxt   = quociente;
    resto_nxt = resto;
    ovf_nxt   = ovf;

    case (state_q)
      IDLE, DONE: begin
        if (st) begin
          state_nxt = CHECK;
          rem_nxt   = REM_W'(dividendo[DVD_W-1:DVS_W]);
          work_nxt  = dividendo[DVS_W-1:0];
          dvs_nxt   = divisor;
          cnt_nxt   = CNT_LAST;
          ovf_nxt   = 1'b0;
        end
      end
      CHECK: begin
        // Upper half >= divisor means the quotient needs more than 16 bits (also covers divide by zero).
        if (rem_q >= REM_W'(dvs_q)) begin
          state_nxt = DONE;
          ovf_nxt   = 1'b1;
          quo_nxt   = '1;
          resto_nxt = '0;
        end else begin
          state_nxt = CALC;
          cnt_nxt   = CNT_LAST;
        end
      end
      CALC: begin
        rem_nxt  = step_rem_c;
        work_nxt = {work_q[DVS_W-2:0], step_q_c};
        cnt_nxt  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_nxt = DONE;
          quo_nxt   = {work_q[DVS_W-2:0], step_q_c};
          resto_nxt = DVS_W'(step_rem_c);
        end
      end
      default: state_nxt = IDLE;
    endcase

    idle_nxt = (state_nxt == IDLE);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_divisor_seq.sv
// Directed-vector and random checks for divisor_seq.
module tb_divisor_seq;

  logic        clk;
  logic        reset;
  logic        st;
  logic [31:0] dividendo;
  logic [15:0] divisor;
  logic [15:0] quociente;
  logic [15:0] resto;
  logic        idle;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  divisor_seq dut (
    .clk       (clk),
    .reset     (reset),
    .st        (st),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .idle      (idle),
    .done      (done),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one division, scramble operands after the start edge, wait (bounded) for done.
  task automatic run_div(input logic [31:0] dvd, input logic [15:0] dvs,
                         output int lat, output logic timeout, output logic [15:0] q_at_start);
    @(negedge clk);
    dividendo = dvd;
    divisor   = dvs;
    st        = 1'b1;
    @(posedge clk);
    #1;
    st         = 1'b0;
    dividendo  = $urandom;
    divisor    = 16'($urandom);
    q_at_start = quociente;
    chk("left_idle_done", {30'd0, idle, done}, 32'd0);
    lat     = 0;
    timeout = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  int          lat;
  logic        tmo;
  logic [15:0] qs;

  initial begin
    st        = 1'b0;
    dividendo = '0;
    divisor   = '0;
    reset     = 1'b1;

    vecs[0]  = '{32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 17};
    vecs[1]  = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 17};
    vecs[2]  = '{32'h12345678,   16'h0000,   16'hFFFF,   16'h0000,   1'b1, 1};
    vecs[3]  = '{32'h00010000,   16'h0001,   16'hFFFF,   16'h0000,   1'b1, 1};
    vecs[4]  = '{32'd1000,       16'd33,     16'd30,     16'd10,     1'b0, 17};
    vecs[5]  = '{32'd0,          16'd5,      16'd0,      16'd0,      1'b0, 17};
    vecs[6]  = '{32'h0000FFFF,   16'h0001,   16'hFFFF,   16'h0000,   1'b0, 17};
    vecs[7]  = '{32'hFFFFFFFF,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b1, 1};
    vecs[8]  = '{32'h0000FFFF,   16'hFFFF,   16'h0001,   16'h0000,   1'b0, 17};
    vecs[9]  = '{32'd5,          16'd10,     16'd0,      16'd5,      1'b0, 17};
    vecs[10] = '{32'h00010000,   16'h0002,   16'h8000,   16'h0000,   1'b0, 17};
    vecs[11] = '{32'h7FFFFFFF,   16'h8000,   16'hFFFF,   16'h7FFF,   1'b0, 17};

    // Reset state
    #2 reset = 1'b0;
    #5;
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_q",    {16'd0, quociente}, 32'd0);
    chk("rst_r",    {16'd0, resto},     32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_div(vecs[i].dvd, vecs[i].dvs, lat, tmo, qs);
      chk($sformatf("v%0d_timeout", i), {31'd0, tmo}, 32'd0);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_q", i),   {16'd0, quociente}, {16'd0, vecs[i].q});
      chk($sformatf("v%0d_r", i),   {16'd0, resto},     {16'd0, vecs[i].r});
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf},       {31'd0, vecs[i].ovf});
    end

    // Back-to-back start from DONE: results held across the restart
    run_div(32'd100, 16'd7, lat, tmo, qs);
    chk("b2b_first_q", {16'd0, quociente}, 32'd14);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("done_level", {31'd0, done}, 32'd1);
    end
    run_div(32'd1000, 16'd33, lat, tmo, qs);
    chk("b2b_q_held", {16'd0, qs}, 32'd14);
    chk("b2b_lat", 32'(lat), 32'd17);
    chk("b2b_q",   {16'd0, quociente}, 32'd30);
    chk("b2b_r",   {16'd0, resto},     32'd10);
    chk("b2b_ovf", {31'd0, ovf},       32'd0);

    // Reset in the middle of CALC
    @(negedge clk);
    dividendo = 32'd100;
    divisor   = 16'd7;
    st        = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_idle", {31'd0, idle}, 32'd1);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_ovf",  {31'd0, ovf},  32'd0);
    chk("mid_rst_q",    {16'd0, quociente}, 32'd0);
    chk("mid_rst_r",    {16'd0, resto},     32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_div(32'd100, 16'd7, lat, tmo, qs);
    chk("after_rst_lat", 32'(lat), 32'd17);
    chk("after_rst_q", {16'd0, quociente}, 32'd14);
    chk("after_rst_r", {16'd0, resto},     32'd2);

    // Random sweep against an arithmetic reference
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] dvd;
      logic [15:0] dvs;
      logic [15:0] eq, er;
      logic        eovf, ok;
      int          elat;
      dvs = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      dvd = $urandom;
      if ($urandom_range(0, 3) != 0 && dvs != 16'd0)
        dvd[31:16] = 16'($urandom % dvs);
      eovf = (dvs == 16'd0) || (dvd[31:16] >= dvs);
      if (eovf) begin
        eq = 16'hFFFF; er = 16'h0000; elat = 1;
      end else begin
        eq = 16'(dvd / 32'(dvs)); er = 16'(dvd % 32'(dvs)); elat = 17;
      end
      run_div(dvd, dvs, lat, tmo, qs);
      ok = !tmo && (quociente === eq) && (resto === er) && (ovf === eovf) && (lat == elat);
      if (ok && !eovf)
        ok = ((64'(quociente) * 64'(dvs) + 64'(resto)) == 64'(dvd)) && (resto < dvs);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rand %0h/%0h: got q=%0h r=%0h ovf=%b lat=%0d expected q=%0h r=%0h ovf=%b lat=%0d",
                 dvd, dvs, quociente, resto, ovf, lat, eq, er, eovf, elat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
